// File: rtl/sram_word_ctrl.sv
// 32-bit load/store port to 256K x 16 asynchronous SRAM bridge.
// Each word access runs as two sequenced halfword cycles (low, then high) with fully registered pins.
`timescale 1ns/1ps
module sram_word_ctrl #(
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [18:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  output logic        o_ready,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 17;

  typedef enum logic [2:0] {
    IDLE, LO_ADDR, LO_ACC, HI_ADDR, HI_ACC, DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] word;
    logic [31:0]       wdata;
    logic [3:0]        bmask;
  } req_t;

  state_t           state, state_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic        ce_n_d, we_n_d, oe_n_d, lb_n_d, ub_n_d;
  logic [17:0] addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ack_d, ready_d;
  logic        smp_lo_q, smp_lo_d, smp_hi_q, smp_hi_d;
  logic [15:0] rdata_lo_q;

  // Word alignment: the two byte-offset bits carry no information.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_addr[1:0];

  assign SRAM_DQ = dq_oe_q ? dq_out_q : {16{1'bz}};

  // Next state plus the pin values the current state calls for; pins are registered one cycle later.
  always_comb begin
    state_d  = state;
    req_d    = req_q;
    cnt_d    = cnt;
    ce_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    addr_d   = SRAM_ADDR;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    ack_d    = 1'b0;
    smp_lo_d = 1'b0;
    smp_hi_d = 1'b0;

    case (state)
      LO_ADDR, LO_ACC: begin
        ce_n_d = 1'b0;
        addr_d = {req_q.word, 1'b0};
        if (req_q.we) begin
          dq_oe_d  = 1'b1;
          dq_out_d = req_q.wdata[15:0];
          lb_n_d   = ~req_q.bmask[0];
          ub_n_d   = ~req_q.bmask[1];
        end else begin
          lb_n_d = 1'b0;
          ub_n_d = 1'b0;
        end
      end
      HI_ADDR, HI_ACC: begin
        ce_n_d = 1'b0;
        addr_d = {req_q.word, 1'b1};
        if (req_q.we) begin
          dq_oe_d  = 1'b1;
          dq_out_d = req_q.wdata[31:16];
          lb_n_d   = ~req_q.bmask[2];
          ub_n_d   = ~req_q.bmask[3];
        end else begin
          lb_n_d = 1'b0;
          ub_n_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (state == LO_ACC || state == HI_ACC) begin
      we_n_d = ~req_q.we;
      oe_n_d = req_q.we;
    end

    case (state)
      IDLE: begin
        if (i_req && o_ready) begin
          req_d = '{we: i_we, word: i_addr[18:2], wdata: i_wdata, bmask: i_bmask};
          if (!i_we || (|i_bmask[1:0]))
            state_d = LO_ADDR;
          else if (|i_bmask[3:2])
            state_d = HI_ADDR;
          else
            state_d = DONE;
        end
      end
      LO_ADDR: begin
        state_d = LO_ACC;
        cnt_d   = CNT_W'(ACC_CYCLES - 1);
      end
      LO_ACC: begin
        if (cnt == '0) begin
          smp_lo_d = ~req_q.we;
          state_d  = (req_q.we && !(|req_q.bmask[3:2])) ? DONE : HI_ADDR;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      HI_ADDR: begin
        state_d = HI_ACC;
        cnt_d   = CNT_W'(ACC_CYCLES - 1);
      end
      HI_ACC: begin
        if (cnt == '0) begin
          smp_hi_d = ~req_q.we;
          state_d  = DONE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State, request latch and registered pins; reset parks everything inactive immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      req_q      <= '0;
      cnt        <= '0;
      SRAM_CE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      SRAM_ADDR  <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      o_ack      <= 1'b0;
      o_ready    <= 1'b1;
      smp_lo_q   <= 1'b0;
      smp_hi_q   <= 1'b0;
      rdata_lo_q <= '0;
      o_rdata    <= '0;
    end else begin
      state     <= state_d;
      req_q     <= req_d;
      cnt       <= cnt_d;
      SRAM_CE_N <= ce_n_d;
      SRAM_WE_N <= we_n_d;
      SRAM_OE_N <= oe_n_d;
      SRAM_LB_N <= lb_n_d;
      SRAM_UB_N <= ub_n_d;
      SRAM_ADDR <= addr_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
      o_ack     <= ack_d;
      o_ready   <= ready_d;
      smp_lo_q  <= smp_lo_d;
      smp_hi_q  <= smp_hi_d;
      // Strobes are high during the last OE_N-low pin cycle of each half.
      if (smp_lo_q)
        rdata_lo_q <= SRAM_DQ;
      if (smp_hi_q)
        o_rdata <= {SRAM_DQ, rdata_lo_q};
    end
  end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Self-checking bench for sram_word_ctrl: SRAM pin model, word-level reference memory,
// directed cases followed by randomized accesses.
`timescale 1ns/1ps
module tb_sram_word_ctrl;

  localparam int unsigned ACC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [18:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        ready, ack;
  logic [31:0] rdata;
  logic [17:0] sa;
  wire  [15:0] sdq;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;

  always #10 clk = ~clk;

  sram_word_ctrl #(.ACC_CYCLES(ACC)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_bmask(bmask), .o_ready(ready), .o_ack(ack),
    .o_rdata(rdata), .SRAM_ADDR(sa), .SRAM_DQ(sdq), .SRAM_CE_N(ce_n),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );

  // Asynchronous SRAM model; "probe" drives a marker so an idle bus can be told apart from a driven one.
  logic [15:0] sram [0:262143];
  logic        probe = 1'b0;
  assign sdq = probe ? 16'hA5C3 : ((!ce_n && !oe_n) ? sram[sa] : 16'hzzzz);

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram[sa][7:0]  <= sdq[7:0];
      if (!ub_n) sram[sa][15:8] <= sdq[15:8];
    end
  end

  // Pin activity monitor for the current access.
  int          ce_cnt, we_cnt, oe_cnt;
  bit          seen, lb_low, ub_low;
  logic [17:0] first_addr, last_addr;

  always @(negedge clk) begin
    if (!ce_n) begin
      ce_cnt++;
      if (!seen) first_addr = sa;
      seen      = 1'b1;
      last_addr = sa;
      if (!we_n) we_cnt++;
      if (!oe_n) oe_cnt++;
      if (!lb_n) lb_low = 1'b1;
      if (!ub_n) ub_low = 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level reference memory and last completed read value.
  bit [31:0] ref_mem [int];
  bit [31:0] last_rd = 32'h0;

  function automatic bit [31:0] ref_get(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic ref_write(input logic [18:0] a, input logic [31:0] d, input logic [3:0] m);
    bit [31:0] v;
    v = ref_get(int'(a[18:2]));
    for (int b = 0; b < 4; b++)
      if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[int'(a[18:2])] = v;
  endtask

  task automatic reset_monitor();
    ce_cnt = 0; we_cnt = 0; oe_cnt = 0;
    seen = 1'b0; lb_low = 1'b0; ub_low = 1'b0;
  endtask

  // One handshake: waits for ready, issues, measures accept-to-ack latency, checks against the model.
  task automatic access(input bit w, input logic [18:0] a, input logic [31:0] d,
                        input logic [3:0] m, input string tag);
    int        n, halves, exp_lat;
    bit [31:0] exp;
    bit        lo, hi;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 50);
    if (!ready) check({tag, "_ready_timeout"}, ready, 1'b1);
    reset_monitor();
    req = 1'b1; we = w; addr = a; wdata = d; bmask = m;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      n++;
      if (n == 1) check({tag, "_busy"}, ready, 1'b0);
    end while (!ack && n < 100);
    lo = !w || (|m[1:0]);
    hi = !w || (|m[3:2]);
    halves  = int'(lo) + int'(hi);
    exp_lat = (halves == 0) ? 1 : halves * (1 + ACC) + 1;
    check({tag, "_latency"}, n - 1, exp_lat);
    if (w) begin
      ref_write(a, d, m);
      check({tag, "_rdata_hold"}, rdata, last_rd);
    end else begin
      exp = ref_get(int'(a[18:2]));
      check({tag, "_rdata"}, rdata, exp);
      last_rd = exp;
    end
    check({tag, "_ce_cycles"}, ce_cnt, halves * (1 + ACC));
    check({tag, "_we_cycles"}, we_cnt, w ? halves * ACC : 0);
    check({tag, "_oe_cycles"}, oe_cnt, w ? 0 : 2 * ACC);
    if (halves > 0) begin
      check({tag, "_first_addr"}, first_addr, lo ? {a[18:2], 1'b0} : {a[18:2], 1'b1});
      check({tag, "_last_addr"},  last_addr,  hi ? {a[18:2], 1'b1} : {a[18:2], 1'b0});
    end
    @(negedge clk);
    check({tag, "_ack_pulse"}, ack, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
  end

  initial begin
    int n, accepted, acks, per;
    logic [31:0] d;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; bmask = '0;
    probe = 1'b1;
    reset_monitor();
    #1;
    check("rst_ce_n", ce_n, 1'b1);
    check("rst_we_n", we_n, 1'b1);
    check("rst_oe_n", oe_n, 1'b1);
    check("rst_lb_ub", {lb_n, ub_n}, 2'b11);
    check("rst_addr", sa, 18'h0);
    check("rst_dq_z", sdq, 16'hA5C3);
    check("rst_ack", ack, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    probe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);

    // Full word write and read back.
    access(1'b1, 19'h00010, 32'hDEADBEEF, 4'b1111, "wr_beef");
    access(1'b0, 19'h00010, 32'h0, 4'b0000, "rd_beef");
    check("rd_beef_value", rdata, 32'hDEADBEEF);

    // High-half-only write merges with existing low half.
    access(1'b1, 19'h00020, 32'h11223344, 4'b1111, "wr_1122");
    access(1'b1, 19'h00020, 32'hAA000000, 4'b1000, "wr_hi_only");
    check("hi_only_lb_n_high", lb_low, 1'b0);
    check("hi_only_ub_n_low", ub_low, 1'b1);
    access(1'b0, 19'h00020, 32'h0, 4'b0000, "rd_merge");
    check("rd_merge_value", rdata, 32'hAA223344);

    // Empty mask: no SRAM cycle at all.
    access(1'b1, 19'h00020, 32'hFFFFFFFF, 4'b0000, "wr_mask0");
    access(1'b0, 19'h00020, 32'h0, 4'b0000, "rd_mask0");
    check("rd_mask0_value", rdata, 32'hAA223344);

    // Request held high: only requests presented while ready are taken.
    per = 2 * (1 + ACC) + 2;
    accepted = 0; acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack) acks++;
      d = $urandom;
      req = 1'b1; we = 1'b1; bmask = 4'b1111;
      addr = 19'(19'h10000 + 4 * i); wdata = d;
      if (ready) begin
        accepted++;
        ref_write(addr, d, 4'b1111);
      end
    end
    @(negedge clk);
    req = 1'b0;
    if (ack) acks++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("hold_accepted", accepted, (30 + per - 1) / per);
    check("hold_acks", acks, accepted);
    for (int i = 0; i < 30; i++)
      access(1'b0, 19'(19'h10000 + 4 * i), 32'h0, 4'b0000, "hold_rd");

    // Randomized mix over a small address window.
    for (int i = 0; i < 40; i++)
      access(1'($urandom_range(0, 1)), 19'(19'h00200 + 4 * $urandom_range(0, 7)),
             $urandom, 4'($urandom_range(0, 15)), "rnd");

    // Reset during the low-half access of a write.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 50);
    reset_monitor();
    req = 1'b1; we = 1'b1; addr = 19'h7FFF0; wdata = 32'h55AA55AA; bmask = 4'b1111;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      n++;
    end while (we_n && n < 20);
    check("abort_we_seen", we_n, 1'b0);
    rst = 1'b1;
    probe = 1'b1;
    #1;
    check("abort_we_n", we_n, 1'b1);
    check("abort_ce_n", ce_n, 1'b1);
    check("abort_dq_z", sdq, 16'hA5C3);
    check("abort_ack", ack, 1'b0);
    probe = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    check("abort_ack_held", ack, 1'b0);
    check("abort_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 1'b1);
    check("abort_no_ack", ack, 1'b0);
    access(1'b0, 19'h00010, 32'h0, 4'b0000, "post_abort_rd");
    check("post_abort_value", rdata, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
